// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Types and constants shared by the 16-bit MIPS fetch logic.
//   pc_t       : program counter / byte address
//   instr_t    : instruction word
//   NOP_INSTR  : word substituted for out-of-range fetches
//   PC_STEP    : byte increment between consecutive instruction words
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int PC_W   = 16;
    localparam int INSTR_W = 16;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = 16'h0000;
    localparam pc_t    PC_STEP   = 16'h0002;

    // Clear bit 0 so a byte address becomes a halfword-aligned PC.
    function automatic pc_t pc_align(input pc_t pc);
        return pc & ~pc_t'(16'h0001);
    endfunction

endpackage

// File: rtl/fetch_rr_arb.sv
// -----------------------------------------------------------------------------
// fetch_rr_arb
// Two-requester round-robin arbiter for the single instruction-memory read
// port. A requester asking alone is granted at once; when both ask, the one
// that was not granted most recently wins.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   fetch_req    : fetch wants the port this cycle
//   dbg_req      : debug reader wants the port this cycle
//   grant_fetch  : port given to fetch (combinational)
//   grant_dbg    : port given to debug (combinational)
// -----------------------------------------------------------------------------
module fetch_rr_arb
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req,
    input  logic dbg_req,
    output logic grant_fetch,
    output logic grant_dbg
);

    // Set when the most recent grant went to debug.
    logic last_dbg_r;
    logic grant_dbg_s;
    logic grant_fetch_s;

    // Grant decision: contention is resolved against the previous winner.
    always_comb begin
        grant_dbg_s   = 1'b0;
        grant_fetch_s = 1'b0;
        if (dbg_req && fetch_req) begin
            grant_dbg_s = ~last_dbg_r;
        end else begin
            grant_dbg_s = dbg_req;
        end
        grant_fetch_s = fetch_req & ~grant_dbg_s;
    end

    // History flag: only moves when somebody is actually granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg_r <= 1'b0;
        end else if (fetch_req || dbg_req) begin
            last_dbg_r <= grant_dbg_s;
        end else begin
            last_dbg_r <= last_dbg_r;
        end
    end

    assign grant_fetch = grant_fetch_s;
    assign grant_dbg   = grant_dbg_s;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetch sequencer: owns the PC, addresses the combinational instruction
// memory, and registers each fetched word into a valid/ready stage for decode.
// Handles branch/jump redirects, halt, and shares the memory port with a
// debug reader through a round-robin arbiter.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_pc / imem_instr       : memory address out / read data in
//   if_valid, if_ready         : output-stage handshake
//   if_instr, if_pc, if_oob    : fetched word, its address, out-of-range flag
//   redirect_valid/redirect_pc : one-cycle branch/jump request and target
//   halt                       : level; blocks new fetches while high
//   dbg_req, dbg_addr          : debug read request (held until ack), address
//   dbg_ack, dbg_data          : one-cycle completion pulse and read data
// -----------------------------------------------------------------------------
module instr_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int               PC_WIDTH   = 16,
    parameter int               DATA_WIDTH = 16,
    parameter int               INSTR_NUM  = 15,
    parameter logic [15:0]      RESET_PC   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic                  if_oob,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  halt,
    input  logic                  dbg_req,
    input  logic [PC_WIDTH-1:0]   dbg_addr,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int IDX_W = PC_WIDTH / 4;

    logic [PC_WIDTH-1:0]   fetch_pc_r;
    logic                  if_valid_r;
    logic [DATA_WIDTH-1:0] if_instr_r;
    logic [PC_WIDTH-1:0]   if_pc_r;
    logic                  if_oob_r;
    logic                  dbg_ack_r;
    logic [DATA_WIDTH-1:0] dbg_data_r;

    logic                  slot_open_s;
    logic                  fetch_want_s;
    logic                  grant_fetch_s;
    logic                  grant_dbg_s;
    logic [IDX_W-1:0]      fetch_idx_s;
    logic                  fetch_oob_s;
    logic [DATA_WIDTH-1:0] fetch_word_s;
    logic [PC_WIDTH-1:0]   redirect_tgt_s;

    // Fetch request: needs room in the output stage, and is suppressed while
    // halted or in a redirect cycle (the old-path word would be flushed anyway).
    always_comb begin
        slot_open_s  = ~if_valid_r | if_ready;
        fetch_want_s = slot_open_s & ~halt & ~redirect_valid;
    end

    fetch_rr_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_want_s),
        .dbg_req     (dbg_req),
        .grant_fetch (grant_fetch_s),
        .grant_dbg   (grant_dbg_s)
    );

    // Range check and NOP substitution; index uses the same PC bits as the
    // memory decode, so addresses above the array alias back into it.
    always_comb begin
        fetch_idx_s    = fetch_pc_r[IDX_W:1];
        fetch_oob_s    = ({{(32-IDX_W){1'b0}}, fetch_idx_s} >= INSTR_NUM);
        fetch_word_s   = fetch_oob_s ? DATA_WIDTH'(NOP_INSTR) : imem_instr;
        redirect_tgt_s = redirect_pc & ~PC_WIDTH'(1);
    end

    // Memory port mux follows the arbiter.
    assign imem_pc = grant_dbg_s ? dbg_addr : fetch_pc_r;

    // PC and output stage: redirect flushes first, then fetch, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= PC_WIDTH'(RESET_PC);
            if_valid_r <= 1'b0;
            if_instr_r <= DATA_WIDTH'(0);
            if_pc_r    <= PC_WIDTH'(0);
            if_oob_r   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
            if_valid_r <= 1'b0;
        end else if (grant_fetch_s) begin
            fetch_pc_r <= fetch_pc_r + PC_WIDTH'(PC_STEP);
            if_valid_r <= 1'b1;
            if_instr_r <= fetch_word_s;
            if_pc_r    <= fetch_pc_r;
            if_oob_r   <= fetch_oob_s;
        end else if (if_ready) begin
            if_valid_r <= 1'b0;
        end else begin
            if_valid_r <= if_valid_r;
        end
    end

    // Debug read return: data captured only on a grant, ack pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_ack_r  <= 1'b0;
            dbg_data_r <= DATA_WIDTH'(0);
        end else if (grant_dbg_s) begin
            dbg_ack_r  <= 1'b1;
            dbg_data_r <= imem_instr;
        end else begin
            dbg_ack_r  <= 1'b0;
        end
    end

    assign if_valid = if_valid_r;
    assign if_instr = if_instr_r;
    assign if_pc    = if_pc_r;
    assign if_oob   = if_oob_r;
    assign dbg_ack  = dbg_ack_r;
    assign dbg_data = dbg_data_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_ctrl
// Directed scenarios followed by random traffic, all checked against a
// transaction-level model of the fetch sequencer kept in this bench.
// -----------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_oob;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic        dbg_ack;
    logic [15:0] dbg_data;

    logic [15:0] mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int unsigned m_pc;
    bit          m_valid;
    int unsigned m_instr;
    int unsigned m_ipc;
    bit          m_oob;
    bit          m_ack;
    int unsigned m_dbg_data;
    bit          m_dbg_won_last;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_oob         (if_oob),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_ack        (dbg_ack),
        .dbg_data       (dbg_data)
    );

    // Combinational instruction memory
    assign imem_instr = mem[imem_pc[4:1]];

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned word_at(input int unsigned addr);
        return 32'(mem[(addr / 2) % 16]);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_oob = 0;
        m_ack = 0; m_dbg_data = 0; m_dbg_won_last = 0;
    endtask

    task automatic check_outputs(input string where);
        check_val({where, ":if_valid"}, 32'(if_valid), 32'(m_valid));
        check_val({where, ":dbg_ack"},  32'(dbg_ack),  32'(m_ack));
        check_val({where, ":dbg_data"}, 32'(dbg_data), m_dbg_data);
        check_val({where, ":if_pc"},    32'(if_pc),    m_ipc);
        check_val({where, ":if_instr"}, 32'(if_instr), m_instr);
        check_val({where, ":if_oob"},   32'(if_oob),   32'(m_oob));
    endtask

    // One clock: called at a negedge, drives inputs, checks the memory
    // address, advances the model, and checks registered outputs at the next negedge.
    task automatic step(input bit r, input bit h, input bit rv, input int unsigned rpc,
                        input bit dq, input int unsigned da);
        bit fetch_wants, dbg_wins, fetch_wins;
        int unsigned idx;
        if_ready = r; halt = h; redirect_valid = rv; redirect_pc = 16'(rpc);
        dbg_req = dq; dbg_addr = 16'(da);
        fetch_wants = (!m_valid || r) && !h && !rv;
        // Debug wins when alone, or in a tie when fetch was served last.
        dbg_wins   = dq && (!fetch_wants || !m_dbg_won_last);
        fetch_wins = fetch_wants && !dbg_wins;
        #1;
        check_val("imem_pc", 32'(imem_pc), dbg_wins ? (da % 65536) : m_pc);
        if (dbg_wins || fetch_wins) m_dbg_won_last = dbg_wins;
        m_ack = dbg_wins;
        if (dbg_wins) m_dbg_data = word_at(da);
        if (rv) begin
            m_pc    = (rpc % 65536) / 2 * 2;
            m_valid = 0;
        end else if (fetch_wins) begin
            idx     = (m_pc / 2) % 16;
            m_oob   = (idx >= 15);
            m_instr = m_oob ? 0 : word_at(m_pc);
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 2) % 65536;
        end else if (r) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("model");
    endtask

    initial begin
        int  waited;
        bit  got;
        bit  hold_dbg;
        bit  halt_lvl;
        int unsigned hold_addr;

        for (int i = 0; i < 15; i++) mem[i] = 16'(16'h1111 * (i + 1));
        mem[15] = 16'hDEAD;

        rst_n = 1'b0; if_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; dbg_req = 1'b0; dbg_addr = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_val("reset:imem_pc", 32'(imem_pc), 32'h0000);
        rst_n = 1'b1;

        // Startup: sequential fetch
        step(1, 0, 0, 0, 0, 0);
        check_val("start:if_pc0",  32'(if_pc),    32'h0000);
        check_val("start:instr0",  32'(if_instr), 32'h1111);
        step(1, 0, 0, 0, 0, 0);
        check_val("start:if_pc1",  32'(if_pc),    32'h0002);

        // Backpressure for 3 cycles, then resume
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check_val("bp:if_pc_held", 32'(if_pc), 32'h0002);
        step(1, 0, 0, 0, 0, 0);
        check_val("bp:resume_pc",  32'(if_pc), 32'h0004);

        // Redirect to odd address, bit 0 dropped
        step(1, 0, 1, 32'h0009, 0, 0);
        check_val("redir:flush",   32'(if_valid), 32'h0);
        step(1, 0, 0, 0, 0, 0);
        check_val("redir:tgt_pc",  32'(if_pc),    32'h0008);
        check_val("redir:tgt_ins", 32'(if_instr), 32'h5555);

        // Debug contention during continuous fetch
        waited = 0; got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            step(1, 0, 0, 0, 1, 32'h0004);
            waited++;
            if (dbg_ack) got = 1;
        end
        check_val("dbg:ack_seen",  32'(got), 32'h1);
        check_val("dbg:latency_le2", 32'(waited <= 2), 32'h1);
        check_val("dbg:data",      32'(dbg_data), 32'h3333);
        step(1, 0, 0, 0, 0, 0);

        // Out-of-range index 15, then wrap back into the array at 0x20
        step(1, 0, 1, 32'h001C, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_val("oob:pc1c",      32'(if_pc),  32'h001C);
        step(1, 0, 0, 0, 0, 0);
        check_val("oob:pc1e",      32'(if_pc),    32'h001E);
        check_val("oob:flag",      32'(if_oob),   32'h1);
        check_val("oob:nop",       32'(if_instr), 32'h0000);
        step(1, 0, 0, 0, 0, 0);
        check_val("oob:pc20",      32'(if_pc),    32'h0020);
        check_val("oob:clear",     32'(if_oob),   32'h0);

        // Halt with pending output: held, debug every cycle, then drains
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 1, 32'(2 * i));
            check_val("halt:dbg_every", 32'(dbg_ack),  32'h1);
            check_val("halt:held",      32'(if_valid), 32'h1);
        end
        step(1, 1, 0, 0, 0, 0);
        check_val("halt:drain",    32'(if_valid), 32'h0);
        step(1, 1, 0, 0, 0, 0);
        check_val("halt:no_fetch", 32'(if_valid), 32'h0);

        // Random traffic
        hold_dbg = 0; halt_lvl = 0; hold_addr = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold_dbg && ($urandom % 4) == 0) begin
                hold_dbg  = 1;
                hold_addr = $urandom % 65536;
            end
            if (($urandom % 24) == 0) halt_lvl = !halt_lvl;
            step(($urandom % 4) != 0, halt_lvl, ($urandom % 16) == 0,
                 $urandom % 65536, hold_dbg, hold_addr);
            if (m_ack) hold_dbg = 0;
        end

        // Asynchronous reset mid-run
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst:if_valid", 32'(if_valid), 32'h0);
        check_val("arst:if_pc",    32'(if_pc),    32'h0);
        check_val("arst:if_instr", 32'(if_instr), 32'h0);
        check_val("arst:imem_pc",  32'(imem_pc),  32'h0);
        @(negedge clk);
        check_outputs("arst");
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        check_val("arst:first_pc",  32'(if_pc),    32'h0000);
        check_val("arst:first_ins", 32'(if_instr), 32'h1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
